// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared unit IDs and widths for the common data bus, also used
//               by the reservation-station manager and the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

  // Requesters on the common data bus
  localparam int NUM_REQ         = 3;
  localparam int DATA_W          = 32;
  localparam int ROB_ENTRY_WIDTH = 4;

  // Functional-unit identifiers; each value is also that unit's request index
  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BRA = 2'd1,
    FU_LSQ = 2'd2
  } fu_id_e;

  // Index width that stays at least one bit wide for a single requester
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_rr_picker
// Description : rr_picker - combinational round-robin priority encoder.
//               Searches ptr, ptr+1, ... wrapping modulo NUM_REQ and returns
//               a one-hot grant plus the index of the winning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter_rr_picker #(
  parameter int NUM_REQ = cdb_arbiter_pkg::NUM_REQ,
  localparam int IDX_W  = cdb_arbiter_pkg::src_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int cand;

  // Walk the requesters starting at ptr; the wrap is modulo NUM_REQ, so a
  // non-power-of-two NUM_REQ never visits a nonexistent index.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!any && req[IDX_W'(cand)]) begin
        any                = 1'b1;
        grant[IDX_W'(cand)] = 1'b1;
        idx                = IDX_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus arbiter. Grants at most one finished result
//               per cycle in round-robin order and broadcasts it (value, ROB
//               tag, source unit) from a register in the following cycle.
//               ROB back-pressure (cdb_hold) and rollback suppress the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_REQ = cdb_arbiter_pkg::NUM_REQ,
  parameter int DATA_W  = cdb_arbiter_pkg::DATA_W,
  parameter int ROB_W   = cdb_arbiter_pkg::ROB_ENTRY_WIDTH,
  localparam int SRC_W  = cdb_arbiter_pkg::src_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,          // asynchronous, active-low
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob_idx,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      cdb_hold,
  input  logic                      rollback,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [ROB_W-1:0]          cdb_rob_idx,
  output logic [SRC_W-1:0]          cdb_src
);

  import cdb_arbiter_pkg::*;

  logic [SRC_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic               xfer;
  logic [DATA_W-1:0]  sel_data;
  logic [ROB_W-1:0]   sel_rob_idx;
  logic [SRC_W-1:0]   ptr_next;

  cdb_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant gating: rollback and ROB back-pressure both suppress the grant;
  // the payload is never consulted, so ready has no path from req_data.
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    if (!rollback && !cdb_hold && pick_any) begin
      req_ready = pick_grant;
      xfer      = 1'b1;
    end
  end

  // Payload select from the one-hot ready vector; each slice is a constant
  // part-select, so this reduces to an AND-OR mux.
  always_comb begin
    sel_data    = '0;
    sel_rob_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_data    = req_data[i*DATA_W +: DATA_W];
        sel_rob_idx = req_rob_idx[i*ROB_W +: ROB_W];
      end
    end
  end

  // The unit after the winner becomes top priority, wrapping modulo NUM_REQ.
  always_comb begin
    ptr_next = '0;
    if (pick_idx != SRC_W'(NUM_REQ - 1)) begin
      ptr_next = pick_idx + SRC_W'(1);
    end
  end

  // Broadcast register and priority pointer; payload holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid   <= 1'b0;
      cdb_data    <= '0;
      cdb_rob_idx <= '0;
      cdb_src     <= '0;
      ptr         <= '0;
    end else begin
      cdb_valid <= xfer;
      if (xfer) begin
        cdb_data    <= sel_data;
        cdb_rob_idx <= sel_rob_idx;
        cdb_src     <= pick_idx;
        ptr         <= ptr_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter. Inputs change
//               1 ns after the rising edge; outputs are sampled before the
//               next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int ROB_W   = 4;
  localparam int SRC_W   = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*ROB_W-1:0]  req_rob_idx;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_hold;
  logic                      rollback;
  logic                      cdb_valid;
  logic [DATA_W-1:0]         cdb_data;
  logic [ROB_W-1:0]          cdb_rob_idx;
  logic [SRC_W-1:0]          cdb_src;

  int n_total = 0;
  int n_pass  = 0;

  cdb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ROB_W   (ROB_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_rob_idx (req_rob_idx),
    .req_ready   (req_ready),
    .cdb_hold    (cdb_hold),
    .rollback    (rollback),
    .cdb_valid   (cdb_valid),
    .cdb_data    (cdb_data),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_src     (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_unit(input int u, input logic [DATA_W-1:0] d, input logic [ROB_W-1:0] t);
    req_data[u*DATA_W +: DATA_W] = d;
    req_rob_idx[u*ROB_W +: ROB_W] = t;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bcast(input string tag, input logic [DATA_W-1:0] d,
                             input logic [ROB_W-1:0] t, input logic [SRC_W-1:0] s);
    check({tag, ".valid"}, 64'(cdb_valid), 64'd1);
    check({tag, ".data"}, 64'(cdb_data), 64'(d));
    check({tag, ".tag"}, 64'(cdb_rob_idx), 64'(t));
    check({tag, ".src"}, 64'(cdb_src), 64'(s));
  endtask

  logic [2:0] rr_exp [5];

  initial begin
    rst         = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_rob_idx = '0;
    cdb_hold    = 1'b0;
    rollback    = 1'b0;

    // Reset state before any clock edge
    #3;
    check("rst.valid", 64'(cdb_valid), 64'd0);
    check("rst.data", 64'(cdb_data), 64'd0);
    check("rst.tag", 64'(cdb_rob_idx), 64'd0);
    check("rst.src", 64'(cdb_src), 64'd0);
    check("rst.ready", 64'(req_ready), 64'd0);
    step();
    step();
    rst = 1'b1;

    // Single ALU requester
    set_unit(0, 32'h0000_00AA, 4'd5);
    req_valid = 3'b001;
    #1 check("single.ready", 64'(req_ready), 64'b001);
    step();
    check_bcast("single", 32'hAA, 4'd5, 2'd0);
    req_valid = 3'b000;
    #1 check("single.ready_idle", 64'(req_ready), 64'b000);
    step();
    check("single.valid_drop", 64'(cdb_valid), 64'd0);
    check("single.data_hold", 64'(cdb_data), 64'hAA);

    // All three valid from a fresh reset: grants 0,1,2,0,1
    rst = 1'b0;
    #1 rst = 1'b1;
    set_unit(0, 32'h100, 4'd8);
    set_unit(1, 32'h101, 4'd9);
    set_unit(2, 32'h102, 4'd10);
    req_valid = 3'b111;
    rr_exp[0] = 3'd0; rr_exp[1] = 3'd1; rr_exp[2] = 3'd2; rr_exp[3] = 3'd0; rr_exp[4] = 3'd1;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("rr%0d.ready", i), 64'(req_ready), 64'(3'b001 << rr_exp[i]));
      step();
      check_bcast($sformatf("rr%0d", i), 32'h100 + 32'(rr_exp[i]),
                  4'd8 + 4'(rr_exp[i]), 2'(rr_exp[i]));
    end

    // Wrap: ptr = 2, units 0 and 1 valid
    req_valid = 3'b011;
    #1 check("wrap0.ready", 64'(req_ready), 64'b001);
    step();
    check_bcast("wrap0", 32'h100, 4'd8, 2'd0);
    #1 check("wrap1.ready", 64'(req_ready), 64'b010);
    step();
    check_bcast("wrap1", 32'h101, 4'd9, 2'd1);
    req_valid = 3'b000;
    step();
    check("wrap.idle", 64'(cdb_valid), 64'd0);

    // Hold for two cycles with BRA valid (ptr = 2)
    set_unit(1, 32'h0000_0B0B, 4'd3);
    req_valid = 3'b010;
    cdb_hold  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check($sformatf("hold%0d.ready", i), 64'(req_ready), 64'b000);
      step();
      check($sformatf("hold%0d.valid", i), 64'(cdb_valid), 64'd0);
    end
    cdb_hold = 1'b0;
    #1 check("hold.release_ready", 64'(req_ready), 64'b010);
    step();
    check_bcast("hold.bcast", 32'h0B0B, 4'd3, 2'd1);

    // Rollback the cycle after an ALU grant (ptr = 2 -> ALU wins)
    set_unit(0, 32'h0000_0077, 4'd7);
    req_valid = 3'b001;
    #1 check("rb.grant_ready", 64'(req_ready), 64'b001);
    step();
    check_bcast("rb.bcast", 32'h77, 4'd7, 2'd0);
    req_valid = 3'b010;
    rollback  = 1'b1;
    cdb_hold  = 1'b1;
    #1 check("rb.ready", 64'(req_ready), 64'b000);
    check("rb.visible", 64'(cdb_valid), 64'd1);
    step();
    check("rb.valid_drop", 64'(cdb_valid), 64'd0);
    rollback = 1'b0;
    cdb_hold = 1'b0;
    // ptr stayed at 1: with units 0 and 2 pending, unit 2 wins
    set_unit(2, 32'h0000_0222, 4'd12);
    req_valid = 3'b101;
    #1 check("rb.ptr_ready", 64'(req_ready), 64'b100);
    step();
    check_bcast("rb.after", 32'h222, 4'd12, 2'd2);

    // Asynchronous reset mid-broadcast
    req_valid = 3'b110;
    #2 rst = 1'b0;
    #1;
    check("arst.valid", 64'(cdb_valid), 64'd0);
    check("arst.data", 64'(cdb_data), 64'd0);
    check("arst.tag", 64'(cdb_rob_idx), 64'd0);
    check("arst.src", 64'(cdb_src), 64'd0);
    rst = 1'b1;
    #1 check("arst.ready", 64'(req_ready), 64'b010);
    step();
    check("arst.first_src", 64'(cdb_src), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
